preg_stage_skid: RTL

//  Parametrised pipeline stage register for the in-order core.

---
 rtl/preg_stage_skid.sv | 130 +++++++++++++
 1 files changed

// File: rtl/preg_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake and optional skid entry.
// The skid entry lets upstream ready come from a flop, cutting the stall path.
module preg_stage_skid #(
    parameter int PAYLOAD_W  = 64,
    parameter bit SKID_EN    = 1'b1,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic [1:0]           o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [PAYLOAD_W-1:0] main_payload;
    logic [PAYLOAD_W-1:0] skid_payload;
    logic                 ready_q;
    logic                 main_valid;
    logic                 skid_valid;
    logic                 in_fire;
    logic                 out_fire;
    logic                 load_main_in;
    logic                 load_main_skid;
    logic                 load_skid;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign o_ready    = SKID_EN ? ready_q : (~main_valid | i_ready);
    assign in_fire    = i_valid & o_ready;
    assign out_fire   = main_valid & i_ready;
    assign o_valid    = main_valid;
    assign o_payload  = main_payload;
    assign o_count    = {1'b0, main_valid} + {1'b0, skid_valid};

    // Next-state and payload-load decode; flush overrides every transfer.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    next_state   = ONE;
                end else begin
                    next_state = EMPTY;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                    next_state   = ONE;
                end else if (in_fire && SKID_EN) begin
                    load_skid  = 1'b1;
                    next_state = FULL;
                end else if (in_fire) begin
                    // Unreachable without a skid entry: o_ready is low while held and stalled.
                    load_main_in = 1'b1;
                    next_state   = ONE;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end else begin
                    next_state = ONE;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    next_state     = ONE;
                end else begin
                    next_state = FULL;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
        if (i_flush) begin
            next_state     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end else begin
            next_state = next_state;
        end
    end

    // State, registered upstream ready and payload storage.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state        <= EMPTY;
            ready_q      <= 1'b1;
            main_payload <= '0;
            skid_payload <= '0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != FULL);
            if (i_flush) begin
                if (FLUSH_ZERO) begin
                    main_payload <= '0;
                    skid_payload <= '0;
                end
            end else begin
                if (load_main_in) begin
                    main_payload <= i_payload;
                end else if (load_main_skid) begin
                    main_payload <= skid_payload;
                end
                if (load_skid) begin
                    skid_payload <= i_payload;
                end
            end
        end
    end

endmodule
